// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: multi-cycle load-use and HI/LO
// interlocks, branch/jump flushing, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int USE_DELAY_SLOT    = 0,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MDU_LATENCY       = 4,
  parameter int PERF_W            = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IFID_MemWr,
  input  logic [4:0]        IFID_Rs,
  input  logic [4:0]        IFID_Rt,
  input  logic              IDEX_MemRead,
  input  logic [4:0]        IDEX_Rt,
  input  logic [1:0]        ID_willjump,
  input  logic              EX_willbranch,
  input  logic              ID_hilo_use,
  input  logic              EX_mdu_start,
  input  logic              perf_clr,
  output logic [1:0]        PC_choice,
  output logic [1:0]        IFID_choice,
  output logic [1:0]        IDEX_choice,
  output logic              stall,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [1:0] SEL_FLUSH = 2'b00;
  localparam logic [1:0] SEL_NORM  = 2'b01;
  localparam logic [1:0] SEL_KEEP  = 2'b10;

  localparam logic [2:0]        LU_RELOAD  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0]        MDU_RELOAD = 4'(MDU_LATENCY - 1);
  localparam logic [PERF_W-1:0] PERF_MAX   = '1;

  logic [2:0] lu_cnt;
  logic [3:0] mdu_cnt;
  logic       lu_hit;
  logic       lu_stall;
  logic       mdu_stall;
  logic       hold;
  logic       jump_flush;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == PERF_MAX) ? v : v + PERF_W'(1);
  endfunction

  // A store's Rt is write data consumed in MEM, so it cannot cause a load-use hazard.
  assign lu_hit = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                  ((IDEX_Rt == IFID_Rs) || (!IFID_MemWr && (IDEX_Rt == IFID_Rt)));

  assign lu_stall   = lu_hit || (lu_cnt != 3'd0);
  assign mdu_stall  = ID_hilo_use && ((mdu_cnt != 4'd0) || EX_mdu_start);
  assign hold       = lu_stall || mdu_stall;
  assign jump_flush = (USE_DELAY_SLOT == 0) && (ID_willjump != 2'b00);

  always_comb begin
    PC_choice   = SEL_NORM;
    IFID_choice = SEL_NORM;
    IDEX_choice = SEL_NORM;
    if (!reset) begin
      if (EX_willbranch) begin
        IFID_choice = SEL_FLUSH;
        IDEX_choice = SEL_FLUSH;
      end else if (hold) begin
        PC_choice   = SEL_KEEP;
        IFID_choice = SEL_KEEP;
        IDEX_choice = SEL_FLUSH;
      end else if (jump_flush) begin
        IFID_choice = SEL_FLUSH;
      end
    end
  end

  assign stall = (PC_choice == SEL_KEEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      lu_cnt       <= 3'd0;
      mdu_cnt      <= 4'd0;
      stall_cycles <= '0;
    end else begin
      // A taken branch squashes the stalled instruction, so its remaining bubbles go too.
      if (EX_willbranch)
        lu_cnt <= 3'd0;
      else if (lu_hit && (lu_cnt == 3'd0))
        lu_cnt <= LU_RELOAD;
      else if (lu_cnt != 3'd0)
        lu_cnt <= lu_cnt - 3'd1;

      if (EX_mdu_start)
        mdu_cnt <= MDU_RELOAD;
      else if (mdu_cnt != 4'd0)
        mdu_cnt <= mdu_cnt - 4'd1;

      if (perf_clr)
        stall_cycles <= '0;
      else if (stall)
        stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule
